wb_arbiter: RTL and testbench

Two-port command arbiter that shares the single Wishbone bus master between the core's instruction-fetch and load/store units. Each requester sees the same command/busy/err/rdata interface the bus master exposes. The arbiter queues one command per port, grants the bus master to one port at a time, issues that port's command, and routes the result back to the granted port.

---
 rtl/wb_arbiter_pkg.sv | 41 ++++
 rtl/wb_arb_slot.sv | 65 ++++++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types for the two-port Wishbone command arbiter: the bus-master
// command encoding, the arbiter FSM state (visible to benches for probing),
// bus widths, and the grant-selection helper used by the top level.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = DATA_W / 8;

  typedef enum logic [1:0] {
    WISHBONE_CMD_NONE  = 2'd0,
    WISHBONE_CMD_LOAD  = 2'd1,
    WISHBONE_CMD_STORE = 2'd2
  } wb_command_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Picks the port to grant from the set of pending slots. With a single
  // pending slot that slot wins; on a tie, round-robin hands the bus to the
  // port that did not win last time, otherwise port 0 has fixed priority.
  function automatic logic pick_winner(input logic [NUM_PORTS-1:0] pending,
                                       input logic                 last_grant,
                                       input logic                 round_robin);
    logic winner;
    if (pending == 2'b11) begin
      winner = round_robin ? ~last_grant : 1'b0;
    end else begin
      winner = pending[1];
    end
    return winner;
  endfunction

endpackage

// File: rtl/wb_arb_slot.sv
// -----------------------------------------------------------------------------
// wb_arb_slot
// One requester slot of the arbiter. Latches a single command from its port
// when idle, reports busy/err/rdata back to that port, and retires the
// command when the top level signals completion.
//
// Ports:
//   clk_in, reset_in          clock, asynchronous active-low reset
//   cmd, addr, wdata, wmask   command presented by the requester
//   complete                  pulse from the top: the bus master finished
//                             this slot's command on this edge
//   bus_err, bus_rdata        result from the bus master
//   slot_cmd .. slot_wmask    latched command, fed to the top-level mux
//   busy, err, rdata          per-port status returned to the requester
// -----------------------------------------------------------------------------
module wb_arb_slot
  import wb_arbiter_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_in,
  input  wb_command_t       cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  input  logic              complete,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata,
  output wb_command_t       slot_cmd,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_wdata,
  output logic [MASK_W-1:0] slot_wmask,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  // Completion is only ever signalled while busy is high, so it cannot
  // collide with an acceptance; a command offered on the completion edge is
  // dropped because busy is still set when it is sampled.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      slot_cmd   <= WISHBONE_CMD_NONE;
      slot_addr  <= '0;
      slot_wdata <= '0;
      slot_wmask <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else if (complete) begin
      busy <= 1'b0;
      err  <= bus_err;
      if (slot_cmd == WISHBONE_CMD_LOAD && !bus_err) begin
        rdata <= bus_rdata;
      end
    end else if (!busy && cmd != WISHBONE_CMD_NONE) begin
      slot_cmd   <= cmd;
      slot_addr  <= addr;
      slot_wdata <= wdata;
      slot_wmask <= wmask;
      busy       <= 1'b1;
      err        <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares one Wishbone bus master between the load/store unit (port 0) and
// the instruction-fetch unit (port 1). Each port queues one command in its
// slot; the FSM grants one slot at a time, pulses its command to the master
// for a single cycle, waits for the master to drop busy, then routes the
// result back to the granted port.
//
// Parameters:
//   ROUND_ROBIN   1: alternate on contention, 0: port 0 always wins ties
// Ports:
//   clk_in, reset_in                 clock, asynchronous active-low reset
//   cmd_in/addr_in/wdata_in/wmask_in per-port command inputs
//   busy_out/err_out/rdata_out       per-port status
//   cmd_out/addr_out/wdata_out/wmask_out  command to the bus master
//   busy_in/err_in/rdata_in          status from the bus master
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  wb_command_t [NUM_PORTS-1:0]       cmd_in,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_in,
  input  logic [NUM_PORTS-1:0][MASK_W-1:0]  wmask_in,
  output logic [NUM_PORTS-1:0]              busy_out,
  output logic [NUM_PORTS-1:0]              err_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_out,
  output wb_command_t                       cmd_out,
  output logic [ADDR_W-1:0]                 addr_out,
  output logic [DATA_W-1:0]                 wdata_out,
  output logic [MASK_W-1:0]                 wmask_out,
  input  logic                              busy_in,
  input  logic                              err_in,
  input  logic [DATA_W-1:0]                 rdata_in
);

  arb_state_t          state;
  logic                last_grant;
  logic                winner;
  logic [NUM_PORTS-1:0] complete;

  wb_command_t         slot_cmd   [NUM_PORTS];
  logic [ADDR_W-1:0]   slot_addr  [NUM_PORTS];
  logic [DATA_W-1:0]   slot_wdata [NUM_PORTS];
  logic [MASK_W-1:0]   slot_wmask [NUM_PORTS];
  logic                slot_busy  [NUM_PORTS];
  logic                slot_err   [NUM_PORTS];
  logic [DATA_W-1:0]   slot_rdata [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    wb_arb_slot u_slot (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .cmd        (cmd_in[p]),
      .addr       (addr_in[p]),
      .wdata      (wdata_in[p]),
      .wmask      (wmask_in[p]),
      .complete   (complete[p]),
      .bus_err    (err_in),
      .bus_rdata  (rdata_in),
      .slot_cmd   (slot_cmd[p]),
      .slot_addr  (slot_addr[p]),
      .slot_wdata (slot_wdata[p]),
      .slot_wmask (slot_wmask[p]),
      .busy       (slot_busy[p]),
      .err        (slot_err[p]),
      .rdata      (slot_rdata[p])
    );
  end

  assign busy_out  = {slot_busy[1], slot_busy[0]};
  assign err_out   = {slot_err[1], slot_err[0]};
  assign rdata_out = {slot_rdata[1], slot_rdata[0]};

  // In IDLE every busy slot is necessarily un-issued: the granted slot is
  // retired on the same edge the FSM returns to IDLE.
  assign winner = pick_winner(busy_out, last_grant, ROUND_ROBIN);

  // The granted port retires on the first WAIT edge that sees the master idle.
  always_comb begin
    complete = '0;
    if (state == WAIT && !busy_in) begin
      complete[last_grant] = 1'b1;
    end
  end

  // Grant FSM. last_grant doubles as the current grant while a transaction is
  // in flight; it resets to 1 so port 0 wins the first tie. The address/data
  // outputs are only reloaded on a grant, so they hold between transactions.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_out    <= WISHBONE_CMD_NONE;
      addr_out   <= '0;
      wdata_out  <= '0;
      wmask_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|busy_out) begin
            last_grant <= winner;
            cmd_out    <= slot_cmd[winner];
            addr_out   <= slot_addr[winner];
            wdata_out  <= slot_wdata[winner];
            wmask_out  <= slot_wmask[winner];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_out <= WISHBONE_CMD_NONE;
          state   <= WAIT;
        end
        WAIT: begin
          if (!busy_in) begin
            state <= IDLE;
          end
        end
        default: begin
          cmd_out <= WISHBONE_CMD_NONE;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Drives two arbiters in parallel from the same requester inputs: instance 0
// is round-robin, instance 1 is fixed priority. Each instance has its own
// behavioural bus master that answers after a configurable number of cycles.
// Single-port transactions come from a vector table; contention, ignored
// commands and reset mid-transaction are hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NI = 2;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;

  wb_command_t [1:0]       cmd_in   = '{WISHBONE_CMD_NONE, WISHBONE_CMD_NONE};
  logic [1:0][31:0]        addr_in  = '0;
  logic [1:0][31:0]        wdata_in = '0;
  logic [1:0][3:0]         wmask_in = '0;

  logic [1:0]              busy_out_v  [NI];
  logic [1:0]              err_out_v   [NI];
  logic [1:0][31:0]        rdata_out_v [NI];
  wb_command_t             cmd_out_v   [NI];
  logic [31:0]             addr_out_v  [NI];
  logic [31:0]             wdata_out_v [NI];
  logic [3:0]              wmask_out_v [NI];
  logic                    busy_in_v   [NI] = '{default: 1'b0};
  logic                    err_in_v    [NI] = '{default: 1'b0};
  logic [31:0]             rdata_in_v  [NI] = '{default: 32'h0};

  int          slv_lat   = 1;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err   = 1'b0;
  int          slv_cnt   [NI] = '{default: 0};

  int          issue_cnt  [NI] = '{default: 0};
  int          multi_cnt  [NI] = '{default: 0};
  logic        prev_valid [NI] = '{default: 1'b0};
  int          log_port   [NI][64];
  logic [3:0]  log_mask   [NI][64];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    wb_command_t cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          lat;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_other;
  } vec_t;

  vec_t vecs [8];

  always #5 clk_in = ~clk_in;

  wb_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk_in(clk_in), .reset_in(reset_in),
    .cmd_in(cmd_in), .addr_in(addr_in), .wdata_in(wdata_in), .wmask_in(wmask_in),
    .busy_out(busy_out_v[0]), .err_out(err_out_v[0]), .rdata_out(rdata_out_v[0]),
    .cmd_out(cmd_out_v[0]), .addr_out(addr_out_v[0]), .wdata_out(wdata_out_v[0]),
    .wmask_out(wmask_out_v[0]),
    .busy_in(busy_in_v[0]), .err_in(err_in_v[0]), .rdata_in(rdata_in_v[0])
  );

  wb_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk_in(clk_in), .reset_in(reset_in),
    .cmd_in(cmd_in), .addr_in(addr_in), .wdata_in(wdata_in), .wmask_in(wmask_in),
    .busy_out(busy_out_v[1]), .err_out(err_out_v[1]), .rdata_out(rdata_out_v[1]),
    .cmd_out(cmd_out_v[1]), .addr_out(addr_out_v[1]), .wdata_out(wdata_out_v[1]),
    .wmask_out(wmask_out_v[1]),
    .busy_in(busy_in_v[1]), .err_in(err_in_v[1]), .rdata_in(rdata_in_v[1])
  );

  // Bus-master model and issue monitor. The master raises busy when it sees a
  // command, holds it for slv_lat falling edges, then drops it with the
  // configured result. The monitor logs which port (address bit 28) and
  // which mask each issued command carried, and flags any command held
  // valid for more than one cycle.
  always @(negedge clk_in) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_in) begin
        busy_in_v[i] = 1'b0;
        slv_cnt[i]   = 0;
      end else if (slv_cnt[i] > 0) begin
        slv_cnt[i] = slv_cnt[i] - 1;
        if (slv_cnt[i] == 0) begin
          busy_in_v[i]  = 1'b0;
          rdata_in_v[i] = slv_rdata;
          err_in_v[i]   = slv_err;
        end
      end else if (cmd_out_v[i] != WISHBONE_CMD_NONE) begin
        busy_in_v[i] = 1'b1;
        slv_cnt[i]   = slv_lat;
      end

      if (cmd_out_v[i] != WISHBONE_CMD_NONE) begin
        if (prev_valid[i]) multi_cnt[i] = multi_cnt[i] + 1;
        if (issue_cnt[i] < 64) begin
          log_port[i][issue_cnt[i]] = int'(addr_out_v[i][28]);
          log_mask[i][issue_cnt[i]] = wmask_out_v[i];
        end
        issue_cnt[i]  = issue_cnt[i] + 1;
        prev_valid[i] = 1'b1;
      end else begin
        prev_valid[i] = 1'b0;
      end
    end
  end

  // Hard stop in case a sequence loses its way entirely.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (dut%0d): got %h want %h", name, inst, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input wb_command_t c, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] m);
    cmd_in[p]   = c;
    addr_in[p]  = a;
    wdata_in[p] = wd;
    wmask_in[p] = m;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((busy_out_v[0] != 2'b00 || busy_out_v[1] != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 0, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // One uncontended transaction, checked cycle by cycle against the
  // expected timing: accept at k, grant at k+1, master sees it at k+2,
  // completion one edge after the master drops busy.
  task automatic runTxn(input vec_t v);
    int o = 1 - v.port;
    int base [NI];
    slv_lat   = v.lat;
    slv_rdata = v.bus_rdata;
    slv_err   = v.bus_err;
    for (int i = 0; i < NI; i++) base[i] = issue_cnt[i];
    applyStimulus(v.port, v.cmd, v.addr, v.wdata, v.wmask);
    tick();
    cmd_in[v.port] = WISHBONE_CMD_NONE;
    for (int i = 0; i < NI; i++) begin
      checkOutput("accept_busy", i, 32'(busy_out_v[i][v.port]), 32'd1);
      checkOutput("accept_err_clear", i, 32'(err_out_v[i][v.port]), 32'd0);
      checkOutput("no_early_cmd", i, 32'(cmd_out_v[i]), 32'(WISHBONE_CMD_NONE));
    end
    tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput("issue_cmd", i, 32'(cmd_out_v[i]), 32'(v.cmd));
      checkOutput("issue_addr", i, addr_out_v[i], v.addr);
      checkOutput("issue_wmask", i, 32'(wmask_out_v[i]), 32'(v.wmask));
      if (v.cmd == WISHBONE_CMD_STORE) checkOutput("issue_wdata", i, wdata_out_v[i], v.wdata);
    end
    tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput("cmd_one_cycle", i, 32'(cmd_out_v[i]), 32'(WISHBONE_CMD_NONE));
      checkOutput("addr_held", i, addr_out_v[i], v.addr);
    end
    repeat (v.lat - 1) tick();
    for (int i = 0; i < NI; i++) checkOutput("busy_before_done", i, 32'(busy_out_v[i][v.port]), 32'd1);
    tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput("busy_done", i, 32'(busy_out_v[i][v.port]), 32'd0);
      checkOutput("rdata", i, rdata_out_v[i][v.port], v.exp_rdata);
      checkOutput("err", i, 32'(err_out_v[i][v.port]), 32'(v.exp_err));
      checkOutput("other_rdata", i, rdata_out_v[i][o], v.exp_other);
      checkOutput("issue_count", i, 32'(issue_cnt[i] - base[i]), 32'd1);
    end
  endtask

  initial begin
    int base [NI];
    int viol [NI];
    int n;

    vecs[0] = '{0, WISHBONE_CMD_LOAD,  32'h0000_0100, 32'h0,         4'hF, 2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1, WISHBONE_CMD_LOAD,  32'h1000_0200, 32'h0,         4'hF, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{0, WISHBONE_CMD_STORE, 32'h0000_0104, 32'h0000_55AA, 4'hC, 3, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D};
    vecs[3] = '{1, WISHBONE_CMD_LOAD,  32'h1000_0208, 32'h0,         4'hF, 2, 32'h99999999, 1'b1, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1, WISHBONE_CMD_STORE, 32'h1000_020C, 32'hA5A5A5A5, 4'h1, 2, 32'h0,         1'b0, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{0, WISHBONE_CMD_LOAD,  32'h0000_0108, 32'h0,         4'hF, 4, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{0, WISHBONE_CMD_STORE, 32'h0000_0500, 32'h0,         4'hF, 1, 32'h0,         1'b0, 32'h0B0B0B0B, 1'b0, 32'h0B0B0B0B};
    vecs[7] = '{1, WISHBONE_CMD_LOAD,  32'h1000_0300, 32'h0,         4'hF, 2, 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0, 32'h0};

    // Reset state.
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput("reset_busy", i, 32'(busy_out_v[i]), 32'd0);
      checkOutput("reset_err", i, 32'(err_out_v[i]), 32'd0);
      checkOutput("reset_rdata", i, rdata_out_v[i][0] | rdata_out_v[i][1], 32'd0);
      checkOutput("reset_cmd", i, 32'(cmd_out_v[i]), 32'(WISHBONE_CMD_NONE));
      checkOutput("reset_addr", i, addr_out_v[i], 32'd0);
    end
    reset_in = 1'b1;
    tick();

    // Table of single-port transactions.
    $display("[TB] single-port vectors");
    for (int v = 0; v < 6; v++) runTxn(vecs[v]);

    // Both ports request on the first edge after reset: port 0 goes first.
    $display("[TB] contention after reset");
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    tick();
    slv_lat   = 2;
    slv_rdata = 32'h600DF00D;
    slv_err   = 1'b0;
    for (int i = 0; i < NI; i++) begin base[i] = issue_cnt[i]; viol[i] = 0; end
    applyStimulus(0, WISHBONE_CMD_STORE, 32'h0000_0010, 32'h11223344, 4'b0011);
    applyStimulus(1, WISHBONE_CMD_LOAD,  32'h1000_0020, 32'h0,        4'hF);
    tick();
    cmd_in[0] = WISHBONE_CMD_NONE;
    cmd_in[1] = WISHBONE_CMD_NONE;
    n = 0;
    while ((busy_out_v[0] != 2'b00 || busy_out_v[1] != 2'b00) && n < 60) begin
      for (int i = 0; i < NI; i++) if (busy_out_v[i][0] && !busy_out_v[i][1]) viol[i]++;
      tick();
      n++;
    end
    checkOutput("contention_done", 0, (n < 60) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < NI; i++) begin
      checkOutput("contention_count", i, 32'(issue_cnt[i] - base[i]), 32'd2);
      checkOutput("contention_first", i, 32'(log_port[i][base[i]]), 32'd0);
      checkOutput("contention_second", i, 32'(log_port[i][base[i] + 1]), 32'd1);
      checkOutput("contention_wmask", i, 32'(log_mask[i][base[i]]), 32'b0011);
      checkOutput("contention_p1_busy", i, 32'(viol[i]), 32'd0);
      checkOutput("contention_p1_rdata", i, rdata_out_v[i][1], 32'h600DF00D);
    end

    // Both ports keep requesting: grants alternate in both modes because a
    // freshly completed port cannot be re-accepted before the next decision.
    $display("[TB] continuous requests");
    slv_lat   = 1;
    slv_rdata = 32'h0B0B0B0B;
    for (int i = 0; i < NI; i++) base[i] = issue_cnt[i];
    applyStimulus(0, WISHBONE_CMD_LOAD, 32'h0000_0400, 32'h0, 4'hF);
    applyStimulus(1, WISHBONE_CMD_LOAD, 32'h1000_0400, 32'h0, 4'hF);
    n = 0;
    while ((issue_cnt[0] - base[0] < 6 || issue_cnt[1] - base[1] < 6) && n < 200) begin
      tick();
      n++;
    end
    cmd_in[0] = WISHBONE_CMD_NONE;
    cmd_in[1] = WISHBONE_CMD_NONE;
    checkOutput("continuous_issued", 0, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    waitIdle("continuous_drain", 60);
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 6; j++)
        checkOutput("continuous_order", i, 32'(log_port[i][base[i] + j]), 32'(j % 2));

    // After a lone port-0 grant, a tie goes to port 1 under round-robin and
    // to port 0 under fixed priority.
    $display("[TB] tie after port-0 grant");
    runTxn(vecs[6]);
    slv_lat = 1;
    for (int i = 0; i < NI; i++) base[i] = issue_cnt[i];
    applyStimulus(0, WISHBONE_CMD_LOAD, 32'h0000_0800, 32'h0, 4'hF);
    applyStimulus(1, WISHBONE_CMD_LOAD, 32'h1000_0800, 32'h0, 4'hF);
    tick();
    cmd_in[0] = WISHBONE_CMD_NONE;
    cmd_in[1] = WISHBONE_CMD_NONE;
    waitIdle("tie_done", 60);
    for (int i = 0; i < NI; i++) begin
      checkOutput("tie_count", i, 32'(issue_cnt[i] - base[i]), 32'd2);
      checkOutput("tie_first", i, 32'(log_port[i][base[i]]), (i == 0) ? 32'd1 : 32'd0);
      checkOutput("tie_second", i, 32'(log_port[i][base[i] + 1]), (i == 0) ? 32'd0 : 32'd1);
    end

    // Port 0 holds its command through the whole transaction, including the
    // completion edge: only the first presentation is accepted.
    $display("[TB] commands while busy");
    slv_lat   = 3;
    slv_rdata = 32'h77778888;
    for (int i = 0; i < NI; i++) base[i] = issue_cnt[i];
    applyStimulus(0, WISHBONE_CMD_LOAD, 32'h0000_0600, 32'h0, 4'hF);
    repeat (6) tick();
    cmd_in[0] = WISHBONE_CMD_NONE;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput("ignore_count", i, 32'(issue_cnt[i] - base[i]), 32'd1);
      checkOutput("ignore_busy", i, 32'(busy_out_v[i][0]), 32'd0);
      checkOutput("ignore_rdata", i, rdata_out_v[i][0], 32'h77778888);
    end

    // Reset asserted mid-cycle while waiting on the master.
    $display("[TB] reset during wait");
    slv_lat = 10;
    applyStimulus(0, WISHBONE_CMD_LOAD, 32'h0000_0700, 32'h0, 4'hF);
    tick();
    cmd_in[0] = WISHBONE_CMD_NONE;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) checkOutput("wait_busy", i, 32'(busy_out_v[i][0]), 32'd1);
    #2;
    reset_in = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("async_busy", i, 32'(busy_out_v[i]), 32'd0);
      checkOutput("async_err", i, 32'(err_out_v[i]), 32'd0);
      checkOutput("async_rdata", i, rdata_out_v[i][0] | rdata_out_v[i][1], 32'd0);
      checkOutput("async_cmd", i, 32'(cmd_out_v[i]), 32'(WISHBONE_CMD_NONE));
      checkOutput("async_addr", i, addr_out_v[i] | wdata_out_v[i] | 32'(wmask_out_v[i]), 32'd0);
    end
    tick();
    reset_in = 1'b1;
    runTxn(vecs[7]);

    for (int i = 0; i < NI; i++) checkOutput("cmd_pulse_width", i, 32'(multi_cnt[i]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
